// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator. It walks a pixel position across an H_TOTAL x
//   V_TOTAL raster and presents that position with its blank/sync
//   qualifiers. It also emits frame and vblank strobes and a completed-frame
//   counter, so game logic can update its state during vertical blanking.
//   Default timing is 640x480@60 from a 25 MHz pixel clock. pix_en allows a
//   faster vga_clk, with the raster advancing only on enabled cycles.
//
// Ports
//   vga_clk      in   pixel clock; all logic runs on its rising edge
//   reset        in   synchronous, active-high
//   pix_en       in   advance one pixel on this cycle
//   DrawX        out  current column, 0..H_TOTAL-1
//   DrawY        out  current row,    0..V_TOTAL-1
//   blank        out  1 while (DrawX,DrawY) lies in the visible region
//   hs, vs       out  syncs, level SYNC_POL while active
//   frame_start  out  one-cycle pulse when the raster wraps to (0,0)
//   vblank_start out  one-cycle pulse when the raster reaches (0,V_VISIBLE)
//   frame_count  out  completed-frame counter, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // The position counters are fixed at 10 bits, so reject larger rasters.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);

  // Region bounds are 11 bits wide, so a bound of exactly 1024 still compares
  // correctly against a zero-extended 10-bit position.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_LO  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_HI  = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_LO  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_HI  = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        frame_start_q, frame_start_d;
  logic        vblank_start_q, vblank_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic [10:0] x_ext, y_ext;
  logic        h_sync_act, v_sync_act;

  // Qualifiers are computed from the next position. They then register on
  // the same edge as DrawX/DrawY, so every output describes one pixel.
  assign x_ext      = {1'b0, x_d};
  assign y_ext      = {1'b0, y_d};
  assign h_sync_act = (x_ext >= H_SYNC_LO) && (x_ext < H_SYNC_HI);
  assign v_sync_act = (y_ext >= V_SYNC_LO) && (y_ext < V_SYNC_HI);

  always_comb begin
    // NOTE: every signal gets a default before any branch. Without these
    // defaults the synthesis tool would infer latches for paths that skip
    // an assignment.
    x_d            = x_q;
    y_d            = y_q;
    blank_d        = blank_q;
    hs_d           = hs_q;
    vs_d           = vs_q;
    frame_start_d  = 1'b0;
    vblank_start_d = 1'b0;
    frame_count_d  = frame_count_q;

    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
        // The last visible line is ending, so the next pixel is (0,V_VISIBLE).
        if (y_q == V_VIS_LAST) begin
          vblank_start_d = 1'b1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end

      blank_d = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
      hs_d    = h_sync_act ? SYNC_POL : ~SYNC_POL;
      vs_d    = v_sync_act ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge vga_clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // which avoids simulation races between sequential blocks.
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      blank_q        <= 1'b1;
      hs_q           <= ~SYNC_POL;
      vs_q           <= ~SYNC_POL;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      blank_q        <= blank_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign DrawX        = x_q;
  assign DrawY        = y_q;
  assign blank        = blank_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  assign frame_count  = frame_count_q;

endmodule
